uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_PER_BIT, default 434, giving clock cycles per bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter DATAWIDTH_BUS, default 8, giving payload bits per frame.
REQ-003 SHALL have parameter STATE_SIZE, default 3, giving the state register width.
REQ-004 SHALL have port UART_RX_CLOCK_50, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port UART_RX_RESET_InHigh, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port UART_RX_rx_In, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port UART_RX_LOCK_InHigh, input, 1, when high no new frame is started.
REQ-008 SHALL have port UART_RX_data_Out, output, DATAWIDTH_BUS, last correctly framed byte.
REQ-009 SHALL have port UART_RX_newData_Out, output, 1, one-cycle pulse: data_Out updated.
REQ-010 SHALL have port UART_RX_frameError_Out, output, 1, one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port UART_RX_busy_Out, output, 1, high in every state except IDLE.

Function
REQ-012 rx_In SHALL pass a 2-flop synchronizer (reset value 1); the FSM SHALL use only the synchronized value rx_s.
REQ-013 The FSM SHALL have five states: IDLE, START, DATA, STOP, CLEANUP.
REQ-014 IDLE: when rx_s=0 and LOCK_InHigh=0, go to START with the bit-clock counter cleared; when rx_s=0 and LOCK_InHigh=1, stay in IDLE.
REQ-015 START: when the counter reaches (CLOCK_PER_BIT-1)/2 (integer division), go to DATA with counter=0 and bit index=0 if rx_s=0; go to IDLE if rx_s=1 (glitch rejected, no output pulse).
REQ-016 DATA: when the counter reaches CLOCK_PER_BIT-1, shift rx_s into shift-register position [bit index] and clear the counter; after index DATAWIDTH_BUS-1, go to STOP.
REQ-017 STOP: when the counter reaches CLOCK_PER_BIT-1 and rx_s=1, load data_Out from the shift register, pulse newData_Out for exactly 1 cycle and go to CLEANUP.
REQ-018 STOP: when the counter reaches CLOCK_PER_BIT-1 and rx_s=0, leave data_Out unchanged, pulse frameError_Out for exactly 1 cycle and go to CLEANUP.
REQ-019 CLEANUP: go to IDLE on the first cycle with rx_s=1, and stay in CLEANUP while rx_s=0 (break condition produces no repeated frames).
REQ-020 The counter width SHALL be $clog2(CLOCK_PER_BIT); the counter SHALL never exceed CLOCK_PER_BIT-1; the bit index SHALL never exceed DATAWIDTH_BUS-1.
REQ-021 LOCK_InHigh asserted mid-frame SHALL NOT abort the frame; it is checked only in IDLE.
REQ-022 Sample points SHALL fall at (CLOCK_PER_BIT-1)/2 + k*CLOCK_PER_BIT cycles after START entry, k=1..DATAWIDTH_BUS+1.
REQ-023 newData_Out and frameError_Out SHALL never be high in the same cycle.
REQ-024 A start bit arriving immediately after the stop-bit midpoint SHALL be accepted once CLEANUP returns to IDLE (back-to-back frames lose nothing).

Reset
REQ-025 Reset SHALL force state=IDLE, counter=0, bit index=0, shift register=0, data_Out=0, newData_Out=0, frameError_Out=0, busy_Out=0 and both synchronizer flops=1, immediately and independent of the clock.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte; after release the FSM SHALL wait for a fresh falling edge.

Verification (bench overrides CLOCK_PER_BIT=16)
REQ-027 Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop high) -> exactly one newData pulse, data_Out=0xA5, frameError never high, busy_Out returns 0.
REQ-028 Drive a 5-cycle low glitch on an idle line -> FSM returns to IDLE from START; no newData or frameError pulse; data_Out unchanged.
REQ-029 Drive frame 0x3C with the stop bit low, then the line high -> one frameError pulse; data_Out holds its previous value (0xA5).
REQ-030 Hold the line low for 30 bit periods -> one frameError pulse; state stays CLEANUP until the line goes high; no second frame decoded.
REQ-031 Drive frames 0x00 and 0xFF back-to-back with one stop bit -> two newData pulses, with data_Out=0x00 then 0xFF.
REQ-032 Assert reset during bit 4 of 0x55, release, then send 0x81 -> all outputs 0 during reset; a single newData pulse follows with data_Out=0x81.
REQ-033 Hold LOCK_InHigh=1 while sending 0x12 -> no pulse; raise LOCK during a 0x34 frame -> data_Out=0x34 is received.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. The line is synchronised, the start bit
//                is confirmed at its midpoint, and data and stop bits are
//                sampled at their centres. A good stop bit publishes the byte
//                with a one-cycle newData pulse. A low stop bit produces a
//                one-cycle frameError pulse and leaves the published byte
//                unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLOCK_PER_BIT = 434,
    parameter int DATAWIDTH_BUS = 8,
    parameter int STATE_SIZE    = 3
) (
    input  logic                     UART_RX_CLOCK_50,
    input  logic                     UART_RX_RESET_InHigh,
    input  logic                     UART_RX_rx_In,
    input  logic                     UART_RX_LOCK_InHigh,
    output logic [DATAWIDTH_BUS-1:0] UART_RX_data_Out,
    output logic                     UART_RX_newData_Out,
    output logic                     UART_RX_frameError_Out,
    output logic                     UART_RX_busy_Out
);

    localparam int c_CNT_W = $clog2(CLOCK_PER_BIT);
    localparam int c_IDX_W = (DATAWIDTH_BUS > 1) ? $clog2(DATAWIDTH_BUS) : 1;

    // The start bit is checked at its midpoint. Every later bit is sampled
    // one full bit period after the previous sample point.
    localparam logic [c_CNT_W-1:0] c_HALF_CNT = c_CNT_W'((CLOCK_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(CLOCK_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATAWIDTH_BUS - 1);

    typedef enum logic [STATE_SIZE-1:0] {
        S_IDLE    = STATE_SIZE'(0),
        S_START   = STATE_SIZE'(1),
        S_DATA    = STATE_SIZE'(2),
        S_STOP    = STATE_SIZE'(3),
        S_CLEANUP = STATE_SIZE'(4)
    } state_t;

    state_t                   state_q, state_d;
    logic [c_CNT_W-1:0]       cnt_q, cnt_d;
    logic [c_IDX_W-1:0]       idx_q, idx_d;
    logic [DATAWIDTH_BUS-1:0] shift_q, shift_d;
    logic [DATAWIDTH_BUS-1:0] data_q, data_d;
    logic                     new_q, new_d;
    logic                     ferr_q, ferr_d;
    logic                     rx_meta_q, rx_s_q;

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge UART_RX_CLOCK_50 or posedge UART_RX_RESET_InHigh) begin
        if (UART_RX_RESET_InHigh) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX_rx_In;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counter, shift register and output registers.
    always_ff @(posedge UART_RX_CLOCK_50 or posedge UART_RX_RESET_InHigh) begin
        if (UART_RX_RESET_InHigh) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            new_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            new_q   <= new_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic. The pulses default low, so each pulse lasts one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        new_d   = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                // The lock is honoured only here, so a frame already in progress is never aborted.
                if (!rx_s_q && !UART_RX_LOCK_InHigh) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == c_HALF_CNT) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line that is high again at the midpoint was a glitch.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == c_LAST_CNT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == c_LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == c_LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = S_CLEANUP;
                    if (rx_s_q) begin
                        data_d = shift_q;
                        new_d  = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CLEANUP: begin
                // Wait here for the line to go high, so a held break is not decoded as repeated frames.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign UART_RX_data_Out       = data_q;
    assign UART_RX_newData_Out    = new_q;
    assign UART_RX_frameError_Out = ferr_q;
    assign UART_RX_busy_Out       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed, table-driven testbench for uart_rx with
//                CLOCK_PER_BIT=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       lock;
    logic [7:0] data_o;
    logic       new_o;
    logic       ferr_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pulse_log[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;

    uart_rx #(
        .CLOCK_PER_BIT(c_CPB),
        .DATAWIDTH_BUS(8),
        .STATE_SIZE   (3)
    ) dut (
        .UART_RX_CLOCK_50      (clk),
        .UART_RX_RESET_InHigh  (rst),
        .UART_RX_rx_In         (rx),
        .UART_RX_LOCK_InHigh   (lock),
        .UART_RX_data_Out      (data_o),
        .UART_RX_newData_Out   (new_o),
        .UART_RX_frameError_Out(ferr_o),
        .UART_RX_busy_Out      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the output pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (new_o) pulse_log.push_back(data_o);
        if (ferr_o) ferr_cnt++;
        if (new_o && ferr_o) both_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_b;
        logic       lock;
        int         exp_new;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            tick(c_CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        rx = 1'b0;
        tick(c_CPB);
        send_bits(d, 8);
        rx = stop_b;
        tick(c_CPB);
        rx = 1'b1;
    endtask

    int n0;
    int f0;

    initial begin
        vecs[0] = '{data: 8'hA5, stop_b: 1'b1, lock: 1'b0, exp_new: 1, exp_ferr: 0, exp_data: 8'hA5};
        vecs[1] = '{data: 8'h3C, stop_b: 1'b0, lock: 1'b0, exp_new: 0, exp_ferr: 1, exp_data: 8'hA5};
        vecs[2] = '{data: 8'h12, stop_b: 1'b1, lock: 1'b1, exp_new: 0, exp_ferr: 0, exp_data: 8'hA5};
        vecs[3] = '{data: 8'h5A, stop_b: 1'b1, lock: 1'b0, exp_new: 1, exp_ferr: 0, exp_data: 8'h5A};

        rst  = 1'b1;
        rx   = 1'b1;
        lock = 1'b0;
        #1;
        check("reset_data", int'(data_o), 0);
        check("reset_new", int'(new_o), 0);
        check("reset_ferr", int'(ferr_o), 0);
        check("reset_busy", int'(busy_o), 0);
        tick(3);
        rst = 1'b0;
        tick(5);

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            n0   = pulse_log.size();
            f0   = ferr_cnt;
            lock = vecs[v].lock;
            send_frame(vecs[v].data, vecs[v].stop_b);
            tick(40);
            lock = 1'b0;
            check($sformatf("vec%0d_new", v), pulse_log.size() - n0, vecs[v].exp_new);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_data", v), int'(data_o), int'(vecs[v].exp_data));
            check($sformatf("vec%0d_busy", v), int'(busy_o), 0);
        end

        // 5-cycle glitch: rejected at the start-bit midpoint.
        n0 = pulse_log.size();
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(4);
        check("glitch_busy_mid", int'(busy_o), 1);
        tick(1);
        rx = 1'b1;
        tick(30);
        check("glitch_busy_end", int'(busy_o), 0);
        check("glitch_new", pulse_log.size() - n0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_data", int'(data_o), 8'h5A);

        // Break: line held low for 30 bit periods.
        n0 = pulse_log.size();
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(30 * c_CPB);
        check("break_busy_held", int'(busy_o), 1);
        check("break_ferr_held", ferr_cnt - f0, 1);
        rx = 1'b1;
        tick(40);
        check("break_busy_end", int'(busy_o), 0);
        check("break_ferr_end", ferr_cnt - f0, 1);
        check("break_new", pulse_log.size() - n0, 0);

        // Back-to-back frames with a single stop bit between them.
        n0 = pulse_log.size();
        f0 = ferr_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(40);
        check("b2b_new", pulse_log.size() - n0, 2);
        check("b2b_ferr", ferr_cnt - f0, 0);
        if (pulse_log.size() - n0 == 2) begin
            check("b2b_first", int'(pulse_log[n0]), 8'h00);
            check("b2b_second", int'(pulse_log[n0 + 1]), 8'hFF);
        end

        // Reset asserted in the middle of bit 4 of 0x55.
        n0 = pulse_log.size();
        rx = 1'b0;
        tick(c_CPB);
        send_bits(8'h55, 4);
        rx = 1'b1;
        tick(c_CPB / 2);
        rst = 1'b1;
        #1;
        check("midrst_data", int'(data_o), 0);
        check("midrst_new", int'(new_o), 0);
        check("midrst_ferr", int'(ferr_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        tick(3);
        rst = 1'b0;
        tick(c_CPB * 6);
        check("midrst_idle", int'(busy_o), 0);
        send_frame(8'h81, 1'b1);
        tick(40);
        check("midrst_new_after", pulse_log.size() - n0, 1);
        check("midrst_data_after", int'(data_o), 8'h81);

        // Lock raised after the frame has started does not abort it.
        n0 = pulse_log.size();
        rx = 1'b0;
        tick(c_CPB);
        send_bits(8'h34, 2);
        lock = 1'b1;
        send_bits(8'h34 >> 2, 6);
        rx = 1'b1;
        tick(c_CPB);
        tick(40);
        lock = 1'b0;
        check("lockmid_new", pulse_log.size() - n0, 1);
        check("lockmid_data", int'(data_o), 8'h34);

        check("never_both", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
